// File: rtl/bram_sample_recorder.sv
// ---------------------------------------------------------------------------
// bram_sample_recorder
//
// Records a fixed-length clip of NUM_WORDS signed 16-bit samples into an
// internal buffer, then streams the buffer into PS-shared BRAM through a
// native BRAM port. Each BRAM word holds one sign-extended sample at byte
// address BASE_ADDR + ADDR_INCREMENT*i, matching the sample player's format.
//
// Optional feature (compile-time macro RECORDER_READBACK_EN):
//   After the write burst the clip is read back with a 2-cycle read latency
//   and compared word by word against the buffer; any difference sets the
//   sticky mismatch flag. Without the macro, mismatch is tied low and the
//   write burst goes straight to DONE.
//
// Ports:
//   clk, rst          system clock; asynchronous active-high reset
//   arm               single-cycle pulse, starts a new capture from IDLE/DONE
//   sample_valid      qualifies sample_in for one cycle
//   sample_in         signed 16-bit sample
//   BRAM_*            native BRAM port (BRAM_clk is clk, BRAM_dout only
//                     used by the readback feature)
//   busy              high while capturing, writing or reading back
//   done              high once the clip is in BRAM, until re-armed
//   overrun           sticky: a sample arrived while the buffer was draining
//   mismatch          sticky: readback data differed from the buffer
//   sample_count      samples captured in the current clip
// ---------------------------------------------------------------------------
module bram_sample_recorder #(
  parameter int unsigned NUM_WORDS      = 256,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] ADDR_INCREMENT = 32'd4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             arm,
  input  logic                             sample_valid,
  input  logic signed [15:0]               sample_in,
  output logic [31:0]                      BRAM_addr,
  output logic                             BRAM_clk,
  output logic [31:0]                      BRAM_din,
  input  logic [31:0]                      BRAM_dout,
  output logic                             BRAM_en,
  output logic                             BRAM_rst,
  output logic [3:0]                       BRAM_we,
  output logic                             busy,
  output logic                             done,
  output logic                             overrun,
  output logic                             mismatch,
  output logic [$clog2(NUM_WORDS+1)-1:0]   sample_count
);

  localparam int CW = $clog2(NUM_WORDS + 1);
  localparam int IW = $clog2(NUM_WORDS);

  localparam logic [CW-1:0] LAST_CNT  = CW'(NUM_WORDS - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_WORDS - 1);
  localparam logic [IW-1:0] FIRST_IDX = '0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CAPTURE  = 3'd1,
    S_WRITE    = 3'd2,
`ifdef RECORDER_READBACK_EN
    S_READBACK = 3'd3,
`endif
    S_DONE     = 3'd4
  } state_t;

  state_t                   state;
  logic [IW-1:0]            wr_idx;
  logic signed [31:0]       sample_buf [NUM_WORDS];

  function automatic logic signed [31:0] sign_extend(input logic signed [15:0] s);
    return {{16{s[15]}}, s};
  endfunction

  assign BRAM_clk = clk;

`ifdef RECORDER_READBACK_EN
  localparam int RW = $clog2(NUM_WORDS + 2);
  // Readback cycle c issues address c (c < NUM_WORDS) and checks the word
  // issued two cycles earlier (c >= 2); the last check happens at c = N+1.
  localparam logic [RW-1:0] RB_LAST_ADDR = RW'(NUM_WORDS - 1);
  localparam logic [RW-1:0] RB_FIRST_CMP = RW'(2);
  localparam logic [RW-1:0] RB_END       = RW'(NUM_WORDS + 1);

  logic [RW-1:0] rb_cnt;
  logic [IW-1:0] rb_idx;
  logic          mismatch_r;

  assign rb_idx   = IW'(rb_cnt - RB_FIRST_CMP);
  assign mismatch = mismatch_r;
`else
  logic unused_dout;
  assign unused_dout = ^BRAM_dout;
  assign mismatch    = 1'b0;
`endif

  // Sample buffer: data only, deliberately not reset.
  always_ff @(posedge clk) begin
    if (state == S_CAPTURE && sample_valid) begin
      sample_buf[sample_count[IW-1:0]] <= sign_extend(sample_in);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      BRAM_addr    <= '0;
      BRAM_din     <= '0;
      BRAM_en      <= 1'b0;
      BRAM_we      <= 4'h0;
      BRAM_rst     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
      sample_count <= '0;
      wr_idx       <= '0;
`ifdef RECORDER_READBACK_EN
      rb_cnt       <= '0;
      mismatch_r   <= 1'b0;
`endif
    end else begin
      BRAM_rst <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state        <= S_CAPTURE;
            busy         <= 1'b1;
            done         <= 1'b0;
            sample_count <= '0;
            overrun      <= 1'b0;
`ifdef RECORDER_READBACK_EN
            mismatch_r   <= 1'b0;
`endif
          end
        end

        S_CAPTURE: begin
          if (sample_valid) begin
            sample_count <= sample_count + 1'b1;
            // Last sample: the first write is presented on the next cycle.
            // Word 0 is already in the buffer since NUM_WORDS >= 2.
            if (sample_count == LAST_CNT) begin
              state     <= S_WRITE;
              BRAM_en   <= 1'b1;
              BRAM_we   <= 4'hF;
              BRAM_addr <= BASE_ADDR;
              BRAM_din  <= sample_buf[FIRST_IDX];
              wr_idx    <= '0;
            end
          end
        end

        S_WRITE: begin
          if (sample_valid) begin
            overrun <= 1'b1;
          end
          if (wr_idx == LAST_IDX) begin
            BRAM_we <= 4'h0;
`ifdef RECORDER_READBACK_EN
            state     <= S_READBACK;
            BRAM_en   <= 1'b1;
            BRAM_addr <= BASE_ADDR;
            rb_cnt    <= '0;
`else
            state   <= S_DONE;
            BRAM_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
`endif
          end else begin
            wr_idx    <= wr_idx + 1'b1;
            BRAM_addr <= BRAM_addr + ADDR_INCREMENT;
            BRAM_din  <= sample_buf[wr_idx + 1'b1];
          end
        end

`ifdef RECORDER_READBACK_EN
        S_READBACK: begin
          if (sample_valid) begin
            overrun <= 1'b1;
          end
          rb_cnt <= rb_cnt + 1'b1;
          if (rb_cnt >= RB_LAST_ADDR) begin
            BRAM_en <= 1'b0;
          end else begin
            BRAM_addr <= BRAM_addr + ADDR_INCREMENT;
          end
          // Read data stage: BRAM_dout now holds the word issued at c-2.
          if (rb_cnt >= RB_FIRST_CMP && BRAM_dout != sample_buf[rb_idx]) begin
            mismatch_r <= 1'b1;
          end
          if (rb_cnt == RB_END) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
`endif

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_sample_recorder.sv
// ---------------------------------------------------------------------------
// tb_bram_sample_recorder
//
// Randomized bench for bram_sample_recorder (NUM_WORDS=8, BASE_ADDR=0x100).
// A behavioural BRAM (word array, write log, 2-cycle read pipe with an
// optional corrupted word) sits on the BRAM port; expected clip contents,
// addresses, timing and flags are derived from the sample values driven.
// ---------------------------------------------------------------------------
module tb_bram_sample_recorder;

  localparam int          N    = 8;
  localparam logic [31:0] BASE = 32'h100;
  localparam logic [31:0] INC  = 32'd4;
  localparam logic [31:0] SENT = 32'hDEAD_BEEF;
`ifdef RECORDER_READBACK_EN
  localparam int DONE_LAT = N + N + 2;
`else
  localparam int DONE_LAT = N;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        sample_valid;
  logic [15:0] sample_in;
  logic [31:0] BRAM_addr;
  logic        BRAM_clk;
  logic [31:0] BRAM_din;
  logic [31:0] BRAM_dout;
  logic        BRAM_en;
  logic        BRAM_rst;
  logic [3:0]  BRAM_we;
  logic        busy;
  logic        done;
  logic        overrun;
  logic        mismatch;
  logic [3:0]  sample_count;

  always #5 clk = ~clk;

  bram_sample_recorder #(
    .NUM_WORDS      (N),
    .BASE_ADDR      (BASE),
    .ADDR_INCREMENT (INC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .BRAM_addr    (BRAM_addr),
    .BRAM_clk     (BRAM_clk),
    .BRAM_din     (BRAM_din),
    .BRAM_dout    (BRAM_dout),
    .BRAM_en      (BRAM_en),
    .BRAM_rst     (BRAM_rst),
    .BRAM_we      (BRAM_we),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun),
    .mismatch     (mismatch),
    .sample_count (sample_count)
  );

  // ---------------- behavioural BRAM ----------------
  logic [31:0] mem [N];
  logic [31:0] woff;
  logic [31:0] rd_p1 = '0;
  logic [31:0] rd_p2 = '0;
  int          cyc = 0;
  int          corrupt_idx = -1;
  bit          mem_clr = 1'b0;
  int          wr_cyc_q  [$];
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [3:0]  wr_we_q   [$];

  assign woff      = BRAM_addr - BASE;
  assign BRAM_dout = rd_p2;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_clr) begin
      for (int i = 0; i < N; i++) mem[i] <= SENT;
      wr_cyc_q.delete();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_we_q.delete();
    end else if (BRAM_en && BRAM_we != 4'h0) begin
      wr_cyc_q.push_back(cyc + 1);
      wr_addr_q.push_back(BRAM_addr);
      wr_data_q.push_back(BRAM_din);
      wr_we_q.push_back(BRAM_we);
      if (woff < 32'(N * 4)) mem[woff[4:2]] <= BRAM_din;
    end
    rd_p2 <= rd_p1;
    if (BRAM_en && BRAM_we == 4'h0 && woff < 32'(N * 4))
      rd_p1 <= mem[woff[4:2]] ^ ((int'(woff[4:2]) == corrupt_idx) ? 32'h0000_0100 : 32'h0);
    else
      rd_p1 <= 32'h0;
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  task automatic clear_mem();
    @(negedge clk);
    mem_clr = 1'b1;
    @(negedge clk);
    mem_clr = 1'b0;
  endtask

  // Arms, feeds N samples, returns at the negedge of the first write cycle.
  task automatic capture(input logic [15:0] s [N], input int gap_lo, input int gap_hi,
                         input bit stray_arm, output int store_cyc);
    int g;
    @(negedge clk);
    arm = 1'b1; sample_valid = 1'b1; sample_in = 16'h5A5A;
    @(negedge clk);
    arm = 1'b0; sample_valid = 1'b0;
    chk("arm_busy", busy, 1);
    chk("arm_done", done, 0);
    chk("arm_count", sample_count, 0);
    chk("arm_overrun", overrun, 0);
    chk("arm_mismatch", mismatch, 0);
    for (int i = 0; i < N; i++) begin
      g = $urandom_range(gap_hi, gap_lo);
      repeat (g) @(negedge clk);
      sample_valid = 1'b1; sample_in = s[i];
      arm = stray_arm && (i == N / 2);
      @(negedge clk);
      sample_valid = 1'b0; arm = 1'b0;
    end
    store_cyc = cyc;
    chk("cap_count", sample_count, N);
    chk("cap_busy", busy, 1);
    chk("cap_en", BRAM_en, 1);
  endtask

  task automatic finish_clip(input logic [15:0] s [N], input int store_cyc,
                             input bit inject_ovr, input bit exp_mm);
    int waited;
    if (inject_ovr) begin
      repeat ($urandom_range(3, 0)) @(negedge clk);
      sample_valid = 1'b1; sample_in = 16'hC0DE;
      @(negedge clk);
      sample_valid = 1'b0;
    end
    waited = 0;
    while (!done && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    chk("done_seen", done, 1);
    chk("done_latency", cyc - store_cyc, DONE_LAT);
    chk("write_count", wr_addr_q.size(), N);
    for (int k = 0; k < N && k < wr_addr_q.size(); k++) begin
      chk($sformatf("wr_addr[%0d]", k), wr_addr_q[k], BASE + INC * k);
      chk($sformatf("wr_data[%0d]", k), wr_data_q[k], sext16(s[k]));
      chk($sformatf("wr_we[%0d]", k), wr_we_q[k], 4'hF);
      chk($sformatf("wr_cycle[%0d]", k), wr_cyc_q[k], store_cyc + 1 + k);
    end
    for (int k = 0; k < N; k++) chk($sformatf("mem[%0d]", k), mem[k], sext16(s[k]));
    chk("done_overrun", overrun, inject_ovr);
    chk("done_mismatch", mismatch, exp_mm);
    chk("done_busy", busy, 0);
    chk("done_en", BRAM_en, 0);
    // DONE holds with stray sample_valid traffic and no further writes.
    repeat (3) begin
      @(negedge clk); sample_valid = 1'b1; sample_in = 16'($urandom);
      @(negedge clk); sample_valid = 1'b0;
    end
    chk("hold_count", sample_count, N);
    chk("hold_done", done, 1);
    chk("hold_writes", wr_addr_q.size(), N);
    chk("hold_overrun", overrun, inject_ovr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s [N];
    int          sc;
    bit          ovr, stray;

    rst = 1'b1; arm = 1'b0; sample_valid = 1'b0; sample_in = '0;
    repeat (3) begin
      @(negedge clk); sample_valid = ~sample_valid;
    end
    sample_valid = 1'b0;
    chk("rst_addr", BRAM_addr, 0);
    chk("rst_din", BRAM_din, 0);
    chk("rst_en", BRAM_en, 0);
    chk("rst_we", BRAM_we, 0);
    chk("rst_bram_rst", BRAM_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_count", sample_count, 0);
    rst = 1'b0;
    #1 chk("rel_bram_rst_hold", BRAM_rst, 1);
    @(negedge clk);
    chk("rel_bram_rst", BRAM_rst, 0);

    clear_mem();
    repeat (6) begin
      @(negedge clk); sample_valid = ~sample_valid; sample_in = 16'($urandom);
    end
    sample_valid = 1'b0;
    @(negedge clk);
    chk("idle_writes", wr_addr_q.size(), 0);
    chk("idle_en", BRAM_en, 0);
    chk("idle_count", sample_count, 0);
    chk("idle_busy", busy, 0);

    // Ramp 1..8, one sample every 3 cycles.
    for (int i = 0; i < N; i++) s[i] = 16'(i + 1);
    clear_mem();
    capture(s, 2, 2, 1'b0, sc);
    finish_clip(s, sc, 1'b0, 1'b0);

    // Full-scale extremes, back-to-back samples.
    for (int i = 0; i < N; i++) s[i] = 16'($urandom);
    s[1] = 16'h8000; s[2] = 16'h7FFF; s[6] = 16'hFFFF;
    clear_mem();
    capture(s, 0, 0, 1'b0, sc);
    finish_clip(s, sc, 1'b0, 1'b0);

    // Arm during capture ignored; sample during write dropped.
    for (int i = 0; i < N; i++) s[i] = 16'($urandom);
    clear_mem();
    capture(s, 0, 2, 1'b1, sc);
    finish_clip(s, sc, 1'b1, 1'b0);

`ifdef RECORDER_READBACK_EN
    for (int i = 0; i < N; i++) s[i] = 16'($urandom);
    corrupt_idx = 5;
    clear_mem();
    capture(s, 0, 1, 1'b0, sc);
    finish_clip(s, sc, 1'b0, 1'b1);
    corrupt_idx = -1;
`endif

    // Randomized clips.
    repeat (6) begin
      for (int i = 0; i < N; i++) s[i] = 16'($urandom);
      ovr   = 1'($urandom_range(1, 0));
      stray = 1'($urandom_range(1, 0));
      clear_mem();
      capture(s, 0, 3, stray, sc);
      finish_clip(s, sc, ovr, 1'b0);
    end

    // Reset during the 4th write cycle.
    for (int i = 0; i < N; i++) s[i] = 16'($urandom);
    clear_mem();
    capture(s, 0, 1, 1'b0, sc);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_en", BRAM_en, 0);
    chk("mid_rst_we", BRAM_we, 0);
    chk("mid_rst_bram_rst", BRAM_rst, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", BRAM_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk); sample_valid = ~sample_valid; sample_in = 16'($urandom);
    end
    sample_valid = 1'b0;
    @(negedge clk);
    chk("partial_count", wr_addr_q.size(), 3);
    for (int k = 0; k < 3 && k < wr_addr_q.size(); k++) begin
      chk($sformatf("partial_addr[%0d]", k), wr_addr_q[k], BASE + INC * k);
      chk($sformatf("partial_data[%0d]", k), wr_data_q[k], sext16(s[k]));
    end
    chk("partial_mem3", mem[3], SENT);
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_en", BRAM_en, 0);
    chk("post_rst_count", sample_count, 0);

    // Recovery clip after reset.
    for (int i = 0; i < N; i++) s[i] = 16'($urandom);
    clear_mem();
    capture(s, 0, 2, 1'b0, sc);
    finish_clip(s, sc, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bram_sample_recorder.md
Name: bram_sample_recorder

Overview:
- Capture-side counterpart to the BRAM sample player. It records a fixed-length clip of 16-bit audio samples into an internal buffer, then writes the buffer into PS-shared BRAM through a native BRAM port.
- The BRAM data format is identical to the one the player reads: one sample per 32-bit word, sign-extended, at byte address BASE_ADDR + 4*i.
- Single clock domain (clk). Samples arrive as clk-synchronous valid strobes from the upstream I2S/mixer path.

Parameters:
- NUM_WORDS, 256, number of samples per clip; must be >= 2.
- BASE_ADDR, 0, BRAM byte address of word 0.
- ADDR_INCREMENT, 4, byte stride between consecutive words.

Ports:
- clk  in  1  system clock; also drives BRAM_clk.
- rst  in  1  reset, asynchronous, active-high.
- arm  in  1  single-cycle pulse; starts a new capture.
- sample_valid  in  1  qualifies sample_in for one clk cycle.
- sample_in  in  16  signed sample.
- BRAM_addr  out  32  BRAM byte address.
- BRAM_clk  out  1  equals clk.
- BRAM_din  out  32  BRAM write data.
- BRAM_dout  in  32  BRAM read data; used only when readback is enabled.
- BRAM_en  out  1  BRAM enable.
- BRAM_rst  out  1  BRAM reset.
- BRAM_we  out  4  BRAM byte write enables.
- busy  out  1  high in CAPTURE, WRITE and READBACK.
- done  out  1  high in DONE.
- overrun  out  1  sticky: a sample was dropped.
- mismatch  out  1  sticky readback error.
- sample_count  out  $clog2(NUM_WORDS+1)  number of samples captured in the current clip.

Behaviour:
- Reset values: BRAM_addr=0, BRAM_din=0, BRAM_en=0, BRAM_we=0, BRAM_rst=1, busy=0, done=0, overrun=0, mismatch=0, sample_count=0, state=IDLE.
  - BRAM_rst deasserts on the first clk edge after rst falls.
- All outputs are registered.
- States: IDLE, CAPTURE, WRITE, READBACK (macro only), DONE.
- IDLE:
  - en=0, we=0.
  - arm -> CAPTURE; sample_count, overrun and mismatch clear on the same edge.
  - sample_valid is ignored.
- CAPTURE:
  - Each sample_valid stores {16{sample_in[15]}, sample_in} into buf[sample_count], then sample_count increments.
  - When the NUM_WORDS-th sample is stored -> WRITE on the same edge.
  - sample_valid on the arm edge is not captured.
- WRITE:
  - Exactly NUM_WORDS consecutive cycles with en=1, we=4'hF.
  - On cycle k (k=0..NUM_WORDS-1): addr=BASE_ADDR+ADDR_INCREMENT*k, din=buf[k].
  - The first write cycle is the cycle immediately after the edge that stored the last sample.
  - Afterwards: en=0, we=0, then -> DONE (or READBACK).
- DONE:
  - done=1, en=0.
  - arm -> CAPTURE with the same clearing as IDLE; done drops on that edge.
  - sample_count holds NUM_WORDS until re-armed.
- arm while busy is ignored.
- Overrun: sample_valid while in WRITE or READBACK sets overrun. The sample is dropped; the buffer and BRAM are unaffected.
- Buffer contents are not reset. Only words written in the current clip reach BRAM.
- Reset mid-WRITE: outputs return to reset values immediately (asynchronous). BRAM holds a partial clip; no further writes occur until the next arm plus a full capture.
- Address arithmetic is 32-bit unsigned and wraps silently; no range check.

Optional Feature:
- Macro: RECORDER_READBACK_EN.
- Defined:
  - After WRITE, enter READBACK: en=1, we=0, addrs BASE_ADDR..+ADDR_INCREMENT*(NUM_WORDS-1) on consecutive cycles.
  - BRAM_dout is sampled with 2-cycle read latency and compared with buf[k].
  - Any inequality sets mismatch (sticky until arm).
  - en drops after the last address; DONE is entered after the last comparison, NUM_WORDS+2 cycles after READBACK entry.
- Not defined: READBACK does not exist, mismatch is tied 0, and WRITE goes directly to DONE.

Test Plan (NUM_WORDS=8, BASE_ADDR=0x100):
1. Reset then release -> all outputs at reset values; BRAM_rst=0 one cycle after release; state IDLE with no BRAM activity even with sample_valid toggling.
2. arm, then 8 samples 0x0001..0x0008 spaced 3 cycles apart -> 8 consecutive write cycles, addr 0x100..0x11C, din 0x00000001..0x00000008, we=4'hF; then done=1, sample_count=8.
3. Sample 0x8000 and 0x7FFF captured -> din 0xFFFF8000 and 0x00007FFF.
4. sample_valid during WRITE, plus an arm during CAPTURE -> overrun=1; the dropped sample never appears in BRAM; the arm does not restart the capture. A later arm from DONE clears overrun.
5. rst asserted on the 4th WRITE cycle -> en/we drop asynchronously; only 0x100..0x108 written; state IDLE after release.
6. With RECORDER_READBACK_EN, model BRAM returning the written data except word 5 corrupted -> mismatch=1, done asserted NUM_WORDS+2 cycles after readback start. With correct data, mismatch=0.
